// File: rtl/aes_sub_bytes_seq.sv
// Iterative AES forward SubBytes: BYTES_PER_CYCLE S-box lookups per clock over a 128-bit state,
// valid/ready on both sides, no overlap between output transfer and next acceptance.

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    // FIPS-197 forward S-box, row-major from entry 00 at the top; entry v sits at index 255-v.
    localparam logic [255:0][7:0] TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign y = TABLE[~a];
endmodule

module aes_sub_bytes_seq #(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);
    localparam int NCHUNK = 16 / BYTES_PER_CYCLE;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
        BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : g_bad_param
        $error("aes_sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SUB  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t                          state;
    logic [CW-1:0]                   cnt;
    // Byte i of the FIPS-ordered state lives at packed index 15-i.
    logic [15:0][7:0]                wr;
    logic [BYTES_PER_CYCLE-1:0][3:0] lane_pos;
    logic [BYTES_PER_CYCLE-1:0][7:0] lane_out;

    for (genvar j = 0; j < BYTES_PER_CYCLE; j++) begin : g_lane
        assign lane_pos[j] = ~4'(int'(cnt) * BYTES_PER_CYCLE + j);
        aes_sbox u_sbox (
            .a (wr[lane_pos[j]]),
            .y (lane_out[j])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            wr    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        wr    <= in_state;
                        cnt   <= '0;
                        state <= SUB;
                    end
                end
                SUB: begin
                    for (int j = 0; j < BYTES_PER_CYCLE; j++)
                        wr[lane_pos[j]] <= lane_out[j];
                    if (cnt == CW'(NCHUNK - 1)) begin
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode state only, so no input reaches an output combinationally.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == SUB) || (state == DONE);
    assign out_state = wr;
endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// Bench for aes_sub_bytes_seq: one instance per legal BYTES_PER_CYCLE, checked against a
// GF(2^8) inverse + affine reference and FIPS-197 vectors.

module tb_aes_sub_bytes_seq;
    localparam logic [127:0] APPB_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] APPB_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] CORN_IN  = 128'h00015363ff0000000000000000000000;
    localparam logic [127:0] CORN_OUT = 128'h637cedfb166363636363636363636363;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       in_valid, in_ready, out_valid, out_ready, busy;
    logic [4:0][127:0] in_state, out_state;

    always #5 clk = ~clk;

    // Instance g runs with BYTES_PER_CYCLE = 2**g; instance 2 is the default build.
    for (genvar g = 0; g < 5; g++) begin : g_dut
        aes_sub_bytes_seq #(.BYTES_PER_CYCLE(1 << g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_state  (in_state[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_state (out_state[g]),
            .busy      (busy[g])
        );
    end

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] sbox_t [256];
    logic [7:0] inv_t  [256];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    // Sbox(x) = affine(x^254); x^254 is the multiplicative inverse, with 0 mapping to 0.
    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] b = 8'h01;
        for (int i = 0; i < 254; i++) b = gmul(b, x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_block(input logic [127:0] x);
        logic [127:0] r = '0;
        for (int i = 0; i < 16; i++) begin
            r = {r[119:0], sbox_t[x[127:120]]};
            x = x << 8;
        end
        return r;
    endfunction

    function automatic logic [127:0] inv_block(input logic [127:0] x);
        logic [127:0] r = '0;
        for (int i = 0; i < 16; i++) begin
            r = {r[119:0], inv_t[x[127:120]]};
            x = x << 8;
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One block through instance g with out_ready high; checks latency, data and return to idle.
    task automatic run_block(input int g, input logic [127:0] data, input logic [127:0] exp,
                             input int lat, input string tag, output logic [127:0] got);
        int k;
        @(negedge clk);
        check({tag, " ready"}, 128'(in_ready[g]), 128'(1));
        in_valid[g]  = 1'b1;
        in_state[g]  = data;
        out_ready[g] = 1'b1;
        @(negedge clk);
        in_valid[g] = 1'b0;
        in_state[g] = rand128();
        k = 0;
        while (!out_valid[g] && k < 40) begin
            @(negedge clk);
            k++;
        end
        check({tag, " latency"}, 128'(k), 128'(lat));
        got = out_state[g];
        check({tag, " data"}, got, exp);
        @(negedge clk);
        check({tag, " after xfer"}, 128'({out_valid[g], in_ready[g], busy[g]}), 128'(3'b010));
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [127:0] got, snap, cur;
        logic [127:0] q_in [$];
        logic [255:0] seen;
        int k, sent, rcvd, cyc;

        for (int v = 0; v < 256; v++) sbox_t[v] = sbox_ref(8'(v));
        for (int v = 0; v < 256; v++) inv_t[sbox_t[v]] = 8'(v);

        rst = 1'b1;
        in_valid = '0; out_ready = '0; in_state = '0;
        repeat (2) @(negedge clk);
        check("reset flags", 128'({out_valid[2], in_ready[2], busy[2]}), 128'(3'b010));
        check("reset data", out_state[2], 128'h0);
        rst = 1'b0;

        run_block(2, APPB_IN, APPB_OUT, 4, "appB", got);
        for (int g = 0; g < 5; g++)
            run_block(g, CORN_IN, CORN_OUT, 16 >> g, $sformatf("corner bpc%0d", 1 << g), got);

        // Backpressure: DONE held with out_ready low, stray in_valid ignored.
        @(negedge clk);
        in_valid[2] = 1'b1; in_state[2] = APPB_IN; out_ready[2] = 1'b0;
        @(negedge clk);
        in_valid[2] = 1'b0;
        k = 0;
        while (!out_valid[2] && k < 40) begin @(negedge clk); k++; end
        check("bp latency", 128'(k), 128'(4));
        snap = out_state[2];
        check("bp data", snap, APPB_OUT);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp hold flags", 128'({out_valid[2], in_ready[2], busy[2]}), 128'(3'b101));
            check("bp hold data", out_state[2], snap);
            in_valid[2] = (i == 3);
            in_state[2] = rand128();
        end
        in_valid[2]  = 1'b0;
        out_ready[2] = 1'b1;
        @(negedge clk);
        check("bp xfer", 128'({out_valid[2], in_ready[2], busy[2]}), 128'(3'b010));
        repeat (3) @(negedge clk);
        check("bp pulse ignored", 128'({out_valid[2], busy[2]}), 128'(2'b00));

        // Asynchronous reset after E2 aborts the block.
        @(negedge clk);
        in_valid[2] = 1'b1; in_state[2] = APPB_IN;
        @(negedge clk);
        in_valid[2] = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst mid flags", 128'({out_valid[2], in_ready[2], busy[2]}), 128'(3'b010));
        check("rst mid data", out_state[2], 128'h0);
        @(negedge clk);
        rst = 1'b0;
        run_block(2, APPB_IN, APPB_OUT, 4, "appB after rst", got);

        // Exhaustive: block v carries byte value v+p at position p.
        seen = '0;
        for (int v = 0; v < 256; v++) begin
            cur = '0;
            for (int p = 0; p < 16; p++) cur = {cur[119:0], 8'(v + p)};
            run_block(2, cur, sub_block(cur), 4, "exhaustive", got);
            seen[got[127:120]] = 1'b1;
        end
        check("bijection", 128'(seen), {128{1'b1}});

        // Streaming with random gaps on both sides.
        sent = 0; rcvd = 0; cyc = 0;
        cur = rand128();
        while (rcvd < 1000 && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            in_valid[2]  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            in_state[2]  = in_valid[2] ? cur : rand128();
            out_ready[2] = ($urandom_range(0, 2) != 0);
            if (in_valid[2] && in_ready[2]) begin
                q_in.push_back(cur);
                sent++;
                cur = rand128();
            end
            if (out_valid[2] && out_ready[2]) begin
                if (q_in.size() == 0) begin
                    check("stream spurious output", 128'(1), 128'(0));
                end else begin
                    snap = q_in.pop_front();
                    check("stream data", out_state[2], sub_block(snap));
                    check("stream inverse", inv_block(out_state[2]), snap);
                end
                rcvd++;
            end
        end
        @(negedge clk);
        in_valid[2] = 1'b0;
        check("stream received", 128'(rcvd), 128'(1000));
        check("stream leftover", 128'(q_in.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
